// File: rtl/m68k_spi_port.sv
// Memory-mapped SPI master on the 68000 lower data lane: byte registers, TX/RX FIFOs,
// programmable SCLK divider, selectable CPOL/CPHA, slave selects and an active-low irq.
module m68k_spi_port #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         NUM_SS     = 2,
  parameter logic [3:0] BASE       = 4'hB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:1]       addr,
  input  logic              as,
  input  logic              rw,
  input  logic              lds,
  inout  wire  [7:0]        data,
  output logic              dtack,
  output logic              irq,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss,
  output logic              dc
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] R_STATUS = 3'd0;
  localparam logic [2:0] R_TXDATA = 3'd1;
  localparam logic [2:0] R_RXDATA = 3'd2;
  localparam logic [2:0] R_CTRL   = 3'd3;
  localparam logic [2:0] R_DIV    = 3'd4;
  localparam logic [2:0] R_SS     = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  logic [1:0]        as_sync_q, lds_sync_q;
  logic              sel_q, dtack_q, oe_q;
  logic [7:0]        rdata_q, rd_mux, div_q;
  logic [4:0]        ctrl_q;
  logic [NUM_SS-1:0] ss_q;
  logic              tx_ovf_q, rx_ovr_q;
  logic [PW:0]       tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [7:0]        rx_mem [FIFO_DEPTH];

  state_t            state_q;
  logic              cpol_q, cpha_q, sclk_q, mosi_q;
  logic [7:0]        divl_q, div_cnt_q, tx_sh_q, rx_sh_q;
  logic [3:0]        half_q;

  logic              unused_addr;
  assign unused_addr = ^addr[19:4];

  // Bus decode on synchronised strobes; addr and rw are stable while AS is low.
  logic       sel, access, rd_acc, wr_acc;
  logic [2:0] reg_sel;
  assign sel     = !as_sync_q[1] && !lds_sync_q[1] && (addr[23:20] == BASE);
  assign access  = sel && !sel_q;
  assign rd_acc  = access && rw;
  assign wr_acc  = access && !rw;
  assign reg_sel = addr[3:1];

  logic tx_empty, tx_full, rx_empty, rx_full, busy;
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = ((tx_wr_q ^ tx_rd_q) == {1'b1, {PW{1'b0}}});
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = ((rx_wr_q ^ rx_rd_q) == {1'b1, {PW{1'b0}}});
  assign busy     = (state_q != S_IDLE);

  logic       tx_push, tx_pop, rx_push, rx_pop, rx_push_ok;
  logic [7:0] rx_byte, tx_head;
  assign tx_push    = wr_acc && (reg_sel == R_TXDATA) && !tx_full;
  assign tx_pop     = (state_q == S_LOAD);
  assign tx_head    = tx_mem[tx_rd_q[PW-1:0]];
  assign rx_pop     = rd_acc && (reg_sel == R_RXDATA) && !rx_empty;
  assign rx_push    = (state_q == S_SHIFT) && (div_cnt_q == divl_q) && (half_q == 4'd15);
  // A CPU pop in the same cycle frees the slot the engine is about to fill.
  assign rx_push_ok = rx_push && (!rx_full || rx_pop);
  assign rx_byte    = cpha_q ? {rx_sh_q[6:0], miso} : rx_sh_q;

  logic [7:0] status;
  assign status = {2'b00, tx_ovf_q, tx_empty, rx_ovr_q, busy, !rx_empty, !tx_full};

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves rd_mux unassigned (no latch).
    rd_mux = 8'h00;
    case (reg_sel)
      R_STATUS: rd_mux = status;
      R_RXDATA: if (!rx_empty) rd_mux = rx_mem[rx_rd_q[PW-1:0]];
      R_CTRL:   rd_mux = {3'b000, ctrl_q};
      R_DIV:    rd_mux = div_q;
      R_SS:     rd_mux[NUM_SS-1:0] = ss_q;
      default:  ;
    endcase
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push)    tx_mem[tx_wr_q[PW-1:0]] <= data;
    if (rx_push_ok) rx_mem[rx_wr_q[PW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      as_sync_q  <= 2'b11;
      lds_sync_q <= 2'b11;
      sel_q      <= 1'b0;
      dtack_q    <= 1'b1;
      oe_q       <= 1'b0;
      rdata_q    <= 8'h00;
      ctrl_q     <= '0;
      div_q      <= 8'd1;
      ss_q       <= '1;
      tx_ovf_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, as the synchroniser chain requires.
      as_sync_q  <= {as_sync_q[0], as};
      lds_sync_q <= {lds_sync_q[0], lds};
      sel_q      <= sel;
      if (access) begin
        dtack_q <= 1'b0;
        oe_q    <= rw;
        if (rw) rdata_q <= rd_mux;
      end else if (as_sync_q[1]) begin
        dtack_q <= 1'b1;
        oe_q    <= 1'b0;
      end
      if (rd_acc && (reg_sel == R_STATUS)) begin
        tx_ovf_q <= 1'b0;
        rx_ovr_q <= 1'b0;
      end
      if (wr_acc) begin
        case (reg_sel)
          R_TXDATA: if (tx_full) tx_ovf_q <= 1'b1;
          R_CTRL:   ctrl_q <= data[4:0];
          R_DIV:    div_q  <= data;
          R_SS:     ss_q   <= data[NUM_SS-1:0];
          default:  ;
        endcase
      end
      if (rx_push && !rx_push_ok) rx_ovr_q <= 1'b1;
      if (tx_push)    tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)     tx_rd_q <= tx_rd_q + 1'b1;
      if (rx_push_ok) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop)     rx_rd_q <= rx_rd_q + 1'b1;
    end
  end

  // SPI engine: sclk toggles at the end of each of 16 half-periods; even halves end on the leading edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      divl_q    <= '0;
      div_cnt_q <= '0;
      half_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (!tx_empty) state_q <= S_LOAD;
        S_LOAD: begin
          cpol_q    <= ctrl_q[0];
          cpha_q    <= ctrl_q[1];
          divl_q    <= div_q;
          sclk_q    <= ctrl_q[0];
          tx_sh_q   <= tx_head;
          div_cnt_q <= '0;
          half_q    <= '0;
          if (!ctrl_q[1]) mosi_q <= tx_head[7];
          state_q   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt_q == divl_q) begin
            div_cnt_q <= '0;
            half_q    <= half_q + 1'b1;
            sclk_q    <= ~sclk_q;
            if (half_q[0] == cpha_q) begin
              rx_sh_q <= {rx_sh_q[6:0], miso};
            end else begin
              mosi_q  <= cpha_q ? tx_sh_q[7] : tx_sh_q[6];
              tx_sh_q <= {tx_sh_q[6:0], 1'b0};
            end
            if (half_q == 4'd15) state_q <= tx_empty ? S_IDLE : S_LOAD;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data  = oe_q ? rdata_q : 8'hzz;
  assign dtack = dtack_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign ss    = ss_q;
  assign dc    = ctrl_q[2];
  assign irq   = !((ctrl_q[3] && !rx_empty) || (ctrl_q[4] && tx_empty && !busy));

endmodule

// File: tb/tb_m68k_spi_port.sv
// Randomised scoreboard bench for m68k_spi_port: MISO looped to MOSI, bus reads and SPI bytes
// are checked by independent monitors against a queue-based model of the register map.
module tb_m68k_spi_port;

  localparam int         DEPTH = 4;
  localparam int         NSS   = 2;
  localparam logic [3:0] BASE  = 4'hB;
  localparam int         CLK_P = 10;

  logic           clk = 1'b0;
  logic           rst;
  logic [23:1]    addr;
  logic           as_n, rw, lds_n;
  wire  [7:0]     data_w;
  logic           tb_oe;
  logic [7:0]     tb_dout;
  logic           dtack, irq, sclk, mosi, miso, dc;
  logic [NSS-1:0] ss;

  always #(CLK_P/2) clk = ~clk;
  assign miso   = mosi;
  assign data_w = tb_oe ? tb_dout : 8'hzz;

  m68k_spi_port #(.FIFO_DEPTH(DEPTH), .NUM_SS(NSS), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .as(as_n), .rw(rw), .lds(lds_n), .data(data_w),
    .dtack(dtack), .irq(irq), .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss), .dc(dc)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard queues and behavioural model state.
  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] spi_exp_q[$];
  longint     first_edge_q[$];
  logic [7:0] m_rx[$];
  bit         m_ovf, m_ovr, eng_busy;
  int         pend;
  logic [4:0] m_ctrl;
  logic [7:0] m_div;

  function automatic logic [7:0] m_status();
    return {2'b00, m_ovf, 1'b1, m_ovr, 1'b0, (m_rx.size() > 0), 1'b1};
  endfunction

  function automatic logic m_irq();
    return !((m_ctrl[3] && m_rx.size() > 0) || m_ctrl[4]);
  endfunction

  task automatic model_reset();
    m_rx.delete(); spi_exp_q.delete();
    m_ovf = 0; m_ovr = 0; eng_busy = 0; pend = 0;
    m_ctrl = '0; m_div = 8'd1;
  endtask

  task automatic bus_cycle(input logic [2:0] off, input bit rd, input logic [7:0] wdata);
    int n;
    @(negedge clk);
    addr = '0; addr[23:20] = BASE; addr[3:1] = off;
    rw = rd; tb_dout = wdata; tb_oe = !rd;
    as_n = 1'b0; lds_n = 1'b0;
    n = 0;
    while (dtack !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("dtack_assert", dtack, 1'b0);
    @(negedge clk);
    as_n = 1'b1; lds_n = 1'b1;
    n = 0;
    while (dtack !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("dtack_release", dtack, 1'b1);
    tb_oe = 1'b0; rw = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] off, input logic [7:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    bus_cycle(off, 1'b1, 8'h00);
  endtask

  task automatic cpu_write(input logic [2:0] off, input logic [7:0] v);
    bus_cycle(off, 1'b0, v);
  endtask

  task automatic set_ctrl(input logic [7:0] v);
    cpu_write(3'd3, v); m_ctrl = v[4:0];
  endtask

  task automatic set_div(input logic [7:0] v);
    cpu_write(3'd4, v); m_div = v;
  endtask

  // The engine starts the first byte at once; later writes queue up to DEPTH, the rest overflow.
  task automatic tx_send(input logic [7:0] v);
    if (!eng_busy) eng_busy = 1;
    else if (pend < DEPTH) pend++;
    else begin
      m_ovf = 1;
      cpu_write(3'd1, v);
      return;
    end
    spi_exp_q.push_back(v);
    if (m_rx.size() < DEPTH) m_rx.push_back(v);
    else m_ovr = 1;
    cpu_write(3'd1, v);
  endtask

  task automatic wait_idle(input int nbytes);
    repeat (nbytes * (1 + 16 * (int'(m_div) + 1)) + 30) @(negedge clk);
    check("spi_bytes_done", spi_exp_q.size(), 0);
    eng_busy = 0; pend = 0;
  endtask

  // Bus-read monitor: every falling dtack on a read pops one expectation.
  initial begin : rd_mon
    logic prev;
    logic [7:0] e;
    string nm;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && prev === 1'b1 && dtack === 1'b0 && rw === 1'b1) begin
        if (rd_exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read: got 0x%0h with no expectation queued", data_w);
        end else begin
          e = rd_exp_q.pop_front();
          nm = rd_name_q.pop_front();
          check(nm, data_w, e);
        end
      end
      prev = dtack;
    end
  end

  // SPI monitor: decodes MOSI on the sample edge implied by the mode the bench programmed.
  initial begin : spi_mon
    int halfcnt;
    logic [7:0] byt;
    longint last_t, t;
    logic prev_sclk;
    halfcnt = 0; byt = '0; last_t = 0; prev_sclk = 1'b0;
    forever begin
      @(sclk or rst);
      if (rst !== 1'b1) begin
        halfcnt = 0; prev_sclk = sclk;
      end else if (sclk !== prev_sclk) begin
        prev_sclk = sclk;
        if (!(halfcnt == 0 && sclk == m_ctrl[0])) begin
          t = $time;
          if (halfcnt > 0) check("sclk_half_period", 32'(t - last_t), 32'((int'(m_div) + 1) * CLK_P));
          else first_edge_q.push_back(t);
          last_t = t;
          if (halfcnt[0] == m_ctrl[1]) begin
            #1;
            byt = {byt[6:0], mosi};
          end
          halfcnt++;
          if (halfcnt == 16) begin
            halfcnt = 0;
            if (spi_exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL spi_unexpected_byte: got 0x%0h", byt);
            end else begin
              check("spi_mosi_byte", byt, spi_exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(CLK_P * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] v, e;
    logic [1:0] mode;
    logic       dcb;
    logic [7:0] ssv;
    int         nb;

    rst = 1'b0; as_n = 1'b1; lds_n = 1'b1; rw = 1'b1; addr = '0; tb_oe = 1'b0; tb_dout = '0;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ss", ss, 2'b11);
    check("rst_dc", dc, 1'b0);
    check("rst_irq", irq, 1'b1);
    check("rst_dtack", dtack, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cpu_read(3'd0, 8'h11, "status_after_reset");
    cpu_read(3'd4, 8'h01, "div_reset");

    // Single byte, mode 0, DIV=1.
    set_div(8'd1);
    set_ctrl(8'h00);
    tx_send(8'hA5);
    wait_idle(1);
    cpu_read(3'd2, m_rx.pop_front(), "rx_a5");

    // All four SPI modes with 0x3C.
    for (int m = 0; m < 4; m++) begin
      set_ctrl(8'(m));
      tx_send(8'h3C);
      wait_idle(1);
      check("sclk_idle_level", sclk, m_ctrl[0]);
      cpu_read(3'd2, m_rx.pop_front(), "rx_mode_3c");
    end

    // Back-to-back burst of DEPTH+2 bytes without draining RX.
    set_ctrl(8'h00);
    set_div(8'd20);
    first_edge_q.delete();
    for (int i = 0; i < DEPTH + 2; i++) tx_send(8'($urandom));
    wait_idle(DEPTH + 1);
    check("burst_byte_count", first_edge_q.size(), DEPTH + 1);
    for (int i = 1; i < first_edge_q.size(); i++)
      check("byte_pitch", 32'(first_edge_q[i] - first_edge_q[i-1]), 32'((1 + 16 * (int'(m_div) + 1)) * CLK_P));
    cpu_read(3'd0, m_status(), "status_sticky_set");
    m_ovf = 0; m_ovr = 0;
    cpu_read(3'd0, m_status(), "status_sticky_cleared");
    while (m_rx.size() > 0) cpu_read(3'd2, m_rx.pop_front(), "rx_burst_order");
    cpu_read(3'd2, 8'h00, "rx_read_empty");
    cpu_read(3'd0, m_status(), "status_drained");

    // Interrupt behaviour.
    set_div(8'd2);
    set_ctrl(8'h08);
    check("irq_rx_idle", irq, m_irq());
    tx_send(8'h5A);
    tx_send(8'hC3);
    wait_idle(2);
    check("irq_rx_pending", irq, m_irq());
    cpu_read(3'd2, m_rx.pop_front(), "rx_irq_1");
    check("irq_rx_one_left", irq, m_irq());
    cpu_read(3'd2, m_rx.pop_front(), "rx_irq_2");
    check("irq_rx_drained", irq, m_irq());
    set_ctrl(8'h10);
    check("irq_txe", irq, m_irq());
    set_ctrl(8'h00);
    check("irq_off", irq, m_irq());

    // Randomised modes, dividers, selects and payloads.
    for (int it = 0; it < 6; it++) begin
      mode = 2'($urandom_range(0, 3));
      dcb  = 1'($urandom_range(0, 1));
      ssv  = 8'($urandom);
      set_ctrl({5'b0, dcb, mode});
      set_div(8'($urandom_range(0, 4)));
      cpu_write(3'd5, ssv);
      check("ss_pins", ss, ssv[NSS-1:0]);
      check("dc_pin", dc, dcb);
      cpu_read(3'd3, {3'b000, m_ctrl}, "ctrl_readback");
      e = '0; e[NSS-1:0] = ssv[NSS-1:0];
      cpu_read(3'd5, e, "ss_readback");
      cpu_read(3'd6, 8'h00, "unmapped_read");
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        v = 8'($urandom);
        tx_send(v);
      end
      wait_idle(nb);
      cpu_read(3'd0, m_status(), "status_random");
      while (m_rx.size() > 0) cpu_read(3'd2, m_rx.pop_front(), "rx_random");
    end

    // Asynchronous reset in the middle of a byte.
    set_ctrl(8'h0C);
    set_div(8'd3);
    cpu_write(3'd5, 8'h00);
    tx_send(8'hF0);
    repeat (15) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_mosi", mosi, 1'b0);
    check("midrst_ss", ss, 2'b11);
    check("midrst_dc", dc, 1'b0);
    check("midrst_irq", irq, 1'b1);
    check("midrst_dtack", dtack, 1'b1);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cpu_read(3'd0, 8'h11, "status_after_midrst");
    cpu_read(3'd3, 8'h00, "ctrl_after_midrst");
    repeat (40) @(negedge clk);
    check("no_bytes_after_rst", spi_exp_q.size(), 0);
    check("reads_all_seen", rd_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m68k_spi_port.md
# m68k_spi_port

Memory-mapped SPI master for the 68000 glue CPLD/FPGA. It decodes one 1 MB region of the 68000 address space and exposes byte registers on the lower data lane (odd addresses). Transmit and receive FIFOs are parametrised, as are the slave-select count and SPI mode. A programmable SCLK divider and an active-low interrupt output are provided. It sits beside the chip-select decoder and drives the SPI pins (sclk, mosi, ss, dc) to the display/SD peripherals.

## Interface
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs; a power of two, at least 2.
- NUM_SS, 2: number of active-low slave selects, 1..8.
- BASE, 4'hB: value of addr[23:20] that selects this block (0xB00000).
- clk  input  1  system clock; the only clock in the block.
- rst  input  1  reset, asynchronous, active-low.
- addr  input  23  68000 address bus, addr[23:1].
- as  input  1  address strobe, active-low.
- rw  input  1  1 = read, 0 = write.
- lds  input  1  lower data strobe, active-low.
- data  inout  8  lower data lane, D7..D0; driven only during a selected read.
- dtack  output  1  active-low acknowledge for this region only; 1 otherwise.
- irq  output  1  active-low interrupt request.
- sclk  output  1  SPI clock.
- mosi  output  1  SPI data out.
- miso  input  1  SPI data in.
- ss  output  NUM_SS  slave selects, active-low.
- dc  output  1  display data(1)/command(0) line.

## Operation
- Register select is addr[3:1]. Offsets 0..5 map to byte addresses 0xB00001, 3, 5, 7, 9, B.
  - 0 STATUS (R): bit0 tx_not_full, bit1 rx_not_empty, bit2 busy, bit3 rx_overrun, bit4 tx_empty, bit5 tx_overflow; bits 7:6 read 0. Reading returns the current value, then clears bits 3 and 5.
  - 1 TXDATA (W): pushes a byte into the TX FIFO. A write while full is dropped and sets tx_overflow.
  - 2 RXDATA (R): pops a byte from the RX FIFO. A read while empty returns 0x00 and changes no state.
  - 3 CTRL (R/W): bit0 cpol, bit1 cpha, bit2 dc, bit3 rx_irq_en, bit4 txe_irq_en; bits 7:5 read 0.
  - 4 DIV (R/W): SCLK half-period is DIV+1 clk cycles.
  - 5 SS (R/W): bits NUM_SS-1:0 drive ss directly; unused bits read 0.
  - Offsets 6 and 7: reads return 0x00, writes are ignored; dtack is still asserted.
- Bus access:
  - as and lds pass through 2-flop synchronisers.
  - An access is the falling edge of the synchronised condition (as low AND lds low AND addr[23:20]==BASE).
  - The register action (push, pop, write, status clear) happens exactly once per bus cycle.
  - Accesses with uds only (lds high) are not decoded; dtack stays 1.
- SPI engine FSM:
  - IDLE: when the TX FIFO is not empty, go to LOAD.
  - LOAD (1 cycle): pop TX; latch cpol, cpha and DIV; if cpha=0, drive the MSB on mosi.
  - SHIFT: 16 half-periods, MSB first. cpha=0 samples on the leading edge and shifts on the trailing edge; cpha=1 shifts on the leading edge and samples on the trailing edge.
  - After the 16th half-period, push the RX byte, then go to LOAD if TX is not empty, else to IDLE.
- busy = (state != IDLE).
- sclk idles at the latched cpol. Changing CTRL or DIV mid-byte affects only the next LOAD.
- RX push when RX is full: the byte is discarded and rx_overrun is set. A same-cycle CPU pop and engine push on a full FIFO: the pop is served first, the push succeeds, and no overrun is flagged.
- irq = !((rx_irq_en & rx_not_empty) | (txe_irq_en & tx_empty & !busy)). It is combinational from registers and glitch-free.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

## Timing
- Reset values: sclk 0, mosi 0, ss all 1, dc 0, irq 1, dtack 1, data hi-Z, CTRL 0, DIV 8'd1, both FIFOs empty, sticky flags 0, FSM in IDLE.
- Reset is asynchronous and aborts any byte in flight; sclk returns to 0 immediately.
- Access latency: the register action and dtack=0 occur on the 3rd rising clk after as/lds go low at the pins.
- Read data is registered in the same cycle dtack falls. It is held, with dtack=0, until the synchronised as goes high; both are released within 2 clks of that.
- A write's data is sampled in the action cycle. The 68000 holds data valid throughout, so this is safe.
- Byte pitch: one byte takes 1 + 16·(DIV+1) clks (DIV=1 gives 33). Back-to-back bytes have no gap.
- The TX byte is visible on the pins one cycle after LOAD; busy rises in LOAD.
- rx_not_empty rises 1 clk after the final half-period.

## Test plan
- Reset, then read STATUS at 0xB00001: returns 0x11, ss=2'b11, irq=1, dtack released after as rises.
- Set DIV=1 and CTRL=0, then write 0xA5 to TXDATA with miso looped back: sclk shows 8 pulses of 2-clk half-periods, mosi carries 1010_0101, and RXDATA reads 0xA5 33 clks after LOAD.
- Run modes 0–3 with a byte loopback of 0x3C: the correct sclk idle level and sample edge per mode, and 0x3C received in every mode.
- Write FIFO_DEPTH+2 bytes back-to-back: the last is dropped with tx_overflow=1, no idle gap appears on sclk, and a STATUS read returns bit5=1, a second read bit5=0.
- Do not drain RX during FIFO_DEPTH+1 transfers: rx_overrun=1 and the first FIFO_DEPTH bytes read back in order.
- Set rx_irq_en=1: irq falls after the first RX push and rises after the last pop. Asserting rst mid-byte returns all outputs to their reset values within one clk.
